// File: rtl/mdbrot_iter_engine.sv
// mdbrot_iter_engine
// Escape-time iterator for one Mandelbrot pixel. A screen coordinate plus a
// view window (centre, per-pixel step) is mapped onto the complex plane as c,
// then z <- z^2 + c is iterated from z = 0 until |z|^2 > 4 or the iteration
// cap is reached. Zoom and pan are driven purely by center_x/center_y/step.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start / ready       request handshake; accepted when start && ready
//   px, py              pixel column / row, captured at accept
//   center_x, center_y  plane value at screen centre, captured at accept
//   step                plane units per pixel (positive), captured at accept
//   done                one-cycle result pulse
//   iter                final iteration count (held until the next result)
//   escaped             1 = left the |z|^2 <= 4 disc, 0 = hit MAX_ITER
//   colour              escaped ? (iter mod 7) + 1 : 0
//
// All plane values are two's complement Q(WIDTH-FRAC).FRAC.
module mdbrot_iter_engine #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned FRAC     = 20,
    parameter int unsigned MAX_ITER = 255,
    parameter int unsigned ITER_W   = $clog2(MAX_ITER + 1),
    parameter int unsigned SCR_W    = 160,
    parameter int unsigned SCR_H    = 120
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [7:0]        px,
    input  logic [6:0]        py,
    input  logic [WIDTH-1:0]  center_x,
    input  logic [WIDTH-1:0]  center_y,
    input  logic [WIDTH-1:0]  step,
    output logic              done,
    output logic [ITER_W-1:0] iter,
    output logic              escaped,
    output logic [2:0]        colour
);

    // Signed pixel offsets need one bit more than the widest screen index.
    localparam int unsigned OFF_W = 10;
    // Full-precision product width and escape-test width (never wraps).
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned MW    = 2 * WIDTH + 1;

    localparam logic signed [MW-1:0] ESC_LIM = MW'(4) <<< FRAC;

    // Parameter sanity checks at elaboration.
    if (WIDTH < FRAC + 5) begin : g_bad_int_bits
        $error("mdbrot_iter_engine: WIDTH-FRAC must be at least 5");
    end
    if (FRAC < 1) begin : g_bad_frac
        $error("mdbrot_iter_engine: FRAC must be at least 1");
    end
    if (MAX_ITER < 1) begin : g_bad_max_iter
        $error("mdbrot_iter_engine: MAX_ITER must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_ITER  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e state_q, state_nx;

    // Captured request
    logic        [7:0]       px_q,   px_nx;
    logic        [6:0]       py_q,   py_nx;
    logic signed [WIDTH-1:0] cx_q,   cx_nx;
    logic signed [WIDTH-1:0] cy_q,   cy_nx;
    logic signed [WIDTH-1:0] step_q, step_nx;

    // Iteration state
    logic signed [WIDTH-1:0] x_c_q,  x_c_nx;
    logic signed [WIDTH-1:0] y_c_q,  y_c_nx;
    logic signed [WIDTH-1:0] xm_q,   xm_nx;
    logic signed [WIDTH-1:0] ym_q,   ym_nx;
    logic        [ITER_W-1:0] cnt_q, cnt_nx;

    // Next values of the registered outputs
    logic              ready_nx;
    logic              done_nx;
    logic [ITER_W-1:0] iter_nx;
    logic              escaped_nx;
    logic [2:0]        colour_nx;

    // Datapath combinational terms
    logic signed [OFF_W-1:0] px_off_c, py_off_c;
    logic signed [WIDTH-1:0] x_scaled_c, y_scaled_c;
    logic signed [PW-1:0]    xx_p_c, yy_p_c, xy_p_c;
    logic signed [PW-1:0]    xm2_c, ym2_c;
    logic signed [MW-1:0]    mag2_c;
    logic                    esc_c;
    logic signed [WIDTH-1:0] xm_upd_c, ym_upd_c;
    logic [2:0]              col_c;

    // Screen-to-plane mapping; screen y grows downward so the row term subtracts.
    // The low WIDTH bits of the full product equal the truncated full product.
    assign px_off_c   = $signed({2'b00, px_q}) - $signed(OFF_W'(SCR_W / 2));
    assign py_off_c   = $signed({3'b000, py_q}) - $signed(OFF_W'(SCR_H / 2));
    assign x_scaled_c = cx_q + WIDTH'(px_off_c) * step_q;
    assign y_scaled_c = cy_q - WIDTH'(py_off_c) * step_q;

    // Squares and cross term at full 2*WIDTH precision.
    assign xx_p_c = PW'(xm_q) * PW'(xm_q);
    assign yy_p_c = PW'(ym_q) * PW'(ym_q);
    assign xy_p_c = PW'(xm_q) * PW'(ym_q);
    assign xm2_c  = xx_p_c >>> FRAC;
    assign ym2_c  = yy_p_c >>> FRAC;

    // Escape test on a sum one bit wider than the squares.
    assign mag2_c = MW'(xm2_c) + MW'(ym2_c);
    assign esc_c  = mag2_c > ESC_LIM;

    // z^2 + c; shifting the cross product by FRAC-1 folds in the factor of 2.
    assign xm_upd_c = WIDTH'(xm2_c - ym2_c) + x_c_q;
    assign ym_upd_c = WIDTH'(xy_p_c >>> (FRAC - 1)) + y_c_q;

    // Colour for an escaped pixel at the current count.
    assign col_c = 3'((32'(cnt_q) % 32'd7) + 32'd1);

    // Next-state and datapath control
    always_comb begin
        state_nx   = state_q;
        px_nx      = px_q;
        py_nx      = py_q;
        cx_nx      = cx_q;
        cy_nx      = cy_q;
        step_nx    = step_q;
        x_c_nx     = x_c_q;
        y_c_nx     = y_c_q;
        xm_nx      = xm_q;
        ym_nx      = ym_q;
        cnt_nx     = cnt_q;
        iter_nx    = iter;
        escaped_nx = escaped;
        colour_nx  = colour;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    px_nx    = px;
                    py_nx    = py;
                    cx_nx    = center_x;
                    cy_nx    = center_y;
                    step_nx  = step;
                    state_nx = ST_SCALE;
                end
            end
            ST_SCALE: begin
                x_c_nx   = x_scaled_c;
                y_c_nx   = y_scaled_c;
                xm_nx    = '0;
                ym_nx    = '0;
                cnt_nx   = '0;
                state_nx = ST_ITER;
            end
            ST_ITER: begin
                // Escape wins over the cap when both hold.
                if (esc_c) begin
                    iter_nx    = cnt_q;
                    escaped_nx = 1'b1;
                    colour_nx  = col_c;
                    state_nx   = ST_DONE;
                end else if (cnt_q == ITER_W'(MAX_ITER)) begin
                    iter_nx    = cnt_q;
                    escaped_nx = 1'b0;
                    colour_nx  = 3'd0;
                    state_nx   = ST_DONE;
                end else begin
                    xm_nx  = xm_upd_c;
                    ym_nx  = ym_upd_c;
                    cnt_nx = cnt_q + ITER_W'(1);
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        ready_nx = (state_nx == ST_IDLE);
        done_nx  = (state_nx == ST_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            px_q    <= '0;
            py_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            step_q  <= '0;
            x_c_q   <= '0;
            y_c_q   <= '0;
            xm_q    <= '0;
            ym_q    <= '0;
            cnt_q   <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            iter    <= '0;
            escaped <= 1'b0;
            colour  <= 3'd0;
        end else begin
            state_q <= state_nx;
            px_q    <= px_nx;
            py_q    <= py_nx;
            cx_q    <= cx_nx;
            cy_q    <= cy_nx;
            step_q  <= step_nx;
            x_c_q   <= x_c_nx;
            y_c_q   <= y_c_nx;
            xm_q    <= xm_nx;
            ym_q    <= ym_nx;
            cnt_q   <= cnt_nx;
            ready   <= ready_nx;
            done    <= done_nx;
            iter    <= iter_nx;
            escaped <= escaped_nx;
            colour  <= colour_nx;
        end
    end

endmodule

// File: doc/mdbrot_iter_engine.md
# mdbrot_iter_engine

Parametrised escape-time iterator for one Mandelbrot pixel, the successor to the fixed-width, no-zoom single-pixel core. It sits between the pixel scan controller and the VGA adapter. It accepts a screen coordinate plus a view window (centre and per-pixel step), maps the coordinate to the complex plane and iterates z ← z² + c. It returns the iteration count, an escape flag and a 3-bit colour. Zoom and pan come from changing `center_x`, `center_y` and `step`; no other logic changes.

## Interface
- WIDTH, 32, total fixed-point width; all plane values are two's complement Q(WIDTH-FRAC).FRAC
- FRAC, 20, fractional bits; elaboration error unless WIDTH-FRAC >= 5
- MAX_ITER, 255, iteration cap (>= 1)
- ITER_W, $clog2(MAX_ITER+1), width of `iter`
- SCR_W, 160, screen width in pixels (origin column = SCR_W/2)
- SCR_H, 120, screen height in pixels (origin row = SCR_H/2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted on an edge where start && ready
- ready  out  1  high only in IDLE
- px  in  8  pixel column, sampled at accept
- py  in  7  pixel row, sampled at accept
- center_x  in  WIDTH  plane real value at column SCR_W/2, sampled at accept
- center_y  in  WIDTH  plane imaginary value at row SCR_H/2, sampled at accept
- step  in  WIDTH  plane units per pixel (positive), sampled at accept
- done  out  1  one-cycle result pulse
- iter  out  ITER_W  final iteration count
- escaped  out  1  1 = left the |z|² ≤ 4 disc; 0 = hit MAX_ITER inside it
- colour  out  3  escaped ? (iter mod 7)+1 : 0

## Operation
- States: IDLE → SCALE → ITER → DONE → IDLE.
- IDLE: ready=1. On start, capture all inputs and go to SCALE. start is ignored in every other state, with no queuing.
- SCALE (1 cycle):
  - x_c = center_x + (px − SCR_W/2)·step
  - y_c = center_y − (py − SCR_H/2)·step (screen y grows downward)
  - Signed pixel offsets; product taken at full width, then truncated to WIDTH.
  - Clear xm, ym and iter to 0. Go to ITER.
- ITER, one test per cycle on the current (xm, ym):
  - xm2 = (xm·xm)>>>FRAC, ym2 = (ym·ym)>>>FRAC, xy = (xm·ym)>>>(FRAC−1)
  - Products are 2·WIDTH bits; arithmetic shift, truncating toward −∞.
  - Escape test: xm2+ym2 > (4<<FRAC). Evaluated at ≥ WIDTH+2 bits; it must never wrap.
  - If escape: escaped←1, go to DONE.
  - Else if iter==MAX_ITER: escaped←0, go to DONE.
  - Else: xm←xm2−ym2+x_c, ym←xy+y_c (both truncated to WIDTH), iter←iter+1.
  - Escape has priority over the cap when both hold at iter==MAX_ITER.
- DONE (1 cycle): done=1. Register iter, escaped and colour. Return to IDLE.
- iter, escaped and colour hold until the next DONE; they do not change at accept.
- Reset (any state, mid-iteration included): immediately return to IDLE and discard the in-flight pixel.

## Timing
- Reset values: ready=1, done=0, iter=0, escaped=0, colour=0; internal xm, ym, x_c, y_c = 0.
- Let N be the final iter value.
  - The accept edge is E0.
  - SCALE occupies E0→E1.
  - Tests run at E1 … E(N+1).
  - done is high for exactly the one cycle following edge E(N+2).
- ready falls the cycle after accept and returns the cycle after done. The earliest next accept is the edge ending the first ready cycle.
- Minimum pixel period is N+4 cycles; the worst case is MAX_ITER+4.
- start held high continuously launches a new pixel on the first edge of each ready cycle.

## Test plan
- Reset mid-ITER: deassert rst_n → within the same cycle ready=1, done=0, iter=0, colour=0. After release, a new start behaves normally.
- center=(0,0), step=1.0 (0x00100000), px=82, py=60 → c=(2,0): iter=2, escaped=1, colour=3, done 4 edges after accept.
- Same window, px=81 → c=(1,0): iter=3, escaped=1, colour=4. This checks that |z|²=4 exactly does not escape.
- Same window, px=80, py=58 → c=(0,2i), negative row offset: iter=2, escaped=1, colour=3.
- center=(−0.5,0), step=1.0, px=80, py=60:
  - Default params → iter=255, escaped=0, colour=0, done 257 edges after accept.
  - Pulse start during ITER → ignored; result unchanged.
- WIDTH=24, FRAC=16, MAX_ITER=15, same c=(−0.5,0) → iter=15, escaped=0. Then c=(2,0) → iter=2, escaped=1.
